fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Shares the single-port 12-bit pixel frame buffer between the VGA scan-out path and the game/render logic. VGA reads always win. Game writes are buffered in a 4-entry write FIFO and drained only on cycles where the VGA path is not reading. A built-in clear sequencer fills the whole 640x480 buffer with one colour using the same idle cycles. The block sits between the VGA timing controller (its rdn/row/col outputs and d_in input) and the frame-buffer RAM.

## Interface
- FIFO_DEPTH, 4: write FIFO entries; power of two, ≥2.
- H_PIX, 640: pixels per line.
- V_PIX, 480: lines per frame.
- vga_clk  in  1  25 MHz pixel clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- vga_rdn  in  1  VGA read request, active low.
- vga_row  in  9  VGA pixel row, 0–479.
- vga_col  in  10  VGA pixel column, 0–639.
- vga_data  out  12  pixel to VGA (bbbb_gggg_rrrr).
- wr_req  in  1  write request from game logic.
- wr_row  in  9  write row.
- wr_col  in  10  write column.
- wr_data  in  12  write colour.
- wr_ack  out  1  write accepted this cycle.
- wr_oob  out  1  one-cycle pulse: an accepted write was out of range and dropped.
- clear_req  in  1  start full-frame clear (level sampled; a one-cycle pulse suffices).
- clear_color  in  12  fill colour, captured when the clear starts.
- clear_busy  out  1  clear in progress.
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH.
- ram_addr  out  19  RAM address = row*640 + col.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  12  RAM write data.
- ram_rdata  in  12  RAM read data; the RAM has synchronous read with 1-cycle latency.

## Operation
- **Port mux (combinational, per cycle):**
  - If vga_rdn=0: ram_addr={vga_row,vga_col} linearised, ram_we=0.
  - Else if in CLEAR: drive the clear counter address with ram_we=1 and ram_wdata=clear colour.
  - Else if FIFO not empty: drive the FIFO head, ram_we=1, and pop.
  - Else: ram_we=0 and ram_addr=0.
- **Address arithmetic:** row*640 = (row<<9)+(row<<7), then + col. All terms are 19 bits, no truncation. Maximum value is 307199.
- **Write acceptance:**
  - wr_ack = wr_req & ~full & ~rst.
  - An accepted write with row≥480 or col≥640 is acked, not enqueued, and pulses wr_oob on the next cycle.
- **FIFO:**
  - Push and pop in the same cycle leave the level unchanged.
  - A push is allowed only when the FIFO is not full at the start of the cycle.
  - The FIFO is never popped while vga_rdn=0 or while in CLEAR.
- **FSM states:**
  - IDLE → CLEAR when clear_req=1. On entry: capture clear_color, set counter row=0, col=0.
  - CLEAR: the counter advances only on cycles where vga_rdn=1 (a write is issued). col wraps 639→0 with row+1.
  - CLEAR → IDLE after the write at (479,639).
  - clear_req while in CLEAR is ignored.
  - wr_req is still accepted during CLEAR until the FIFO is full. Queued entries drain after the clear, so they land on top of the cleared image.
- **Read return:**
  - rd_d is a register holding ~vga_rdn.
  - vga_data = rd_d ? ram_rdata : 12'h000.

## Timing
- **Reset values:** rd_d=0, so vga_data=0. FSM=IDLE, clear_busy=0, fifo_level=0, wr_oob=0, ram_we=0, wr_ack=0.
- **Reset mid-operation:** aborts any clear and discards all FIFO contents, taking effect at the next edge.
- **VGA read latency:** address in cycle N, vga_data valid in cycle N+1. Scan-out is never stalled.
- **Write latency:** with the FIFO empty and vga_rdn=1, an acked write reaches the RAM (ram_we=1) in the cycle after ack.
- **Sustained write throughput:** one write per idle cycle.
- **Clear duration:** 307200 idle cycles. A full frame has 800*525−307200 = 112800 idle cycles, so a clear spans about 3 frames.
- **clear_busy:** goes high the cycle after clear_req is sampled in IDLE. It drops the cycle after the last clear write.
- **fifo_level:** registered; updates one cycle after a push or pop.

## Test plan
- **Write then read back:** with vga_rdn=1, write (10,20,12'hABC) → ack=1. Next cycle: ram_we=1, ram_addr=6420, ram_wdata=ABC. Then a VGA read of (10,20) → vga_data=ABC one cycle later.
- **VGA priority and FIFO fill:** hold vga_rdn=0 and issue 5 back-to-back writes → first 4 acked, 5th wr_ack=0, fifo_level=4, ram_we=0 throughout. Release vga_rdn → 4 RAM writes in consecutive cycles, in order, and the level falls 4→0.
- **Out-of-range write:** write (480,0) → ack=1, wr_oob pulses one cycle, fifo_level stays 0, no ram_we. Repeat with col=640.
- **Full clear:** clear_req with colour 12'h00F under real 800x525 scan timing → exactly 307200 ram_we pulses with addresses 0..307199 ascending, none while vga_rdn=0. clear_busy then falls, and a read of (479,639) returns 00F.
- **Write during clear:** write (0,0,12'hFFF) mid-clear → held in the FIFO until clear_busy falls, then written. A final read of (0,0) returns FFF.
- **Reset mid-clear:** assert rst at counter address 1000 with 2 entries queued → next cycle clear_busy=0, fifo_level=0, ram_we=0, and no further writes.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA reads take the single RAM port first, while
// buffered game writes and the full-frame clear use the remaining idle cycles.
module fb_port_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        vga_rdn,
  input  logic [8:0]  vga_row,
  input  logic [9:0]  vga_col,
  output logic [11:0] vga_data,
  input  logic        wr_req,
  input  logic [8:0]  wr_row,
  input  logic [9:0]  wr_col,
  input  logic [11:0] wr_data,
  output logic        wr_ack,
  output logic        wr_oob,
  input  logic        clear_req,
  input  logic [11:0] clear_color,
  output logic        clear_busy,
  output logic [2:0]  fifo_level,
  output logic [18:0] ram_addr,
  output logic        ram_we,
  output logic [11:0] ram_wdata,
  input  logic [11:0] ram_rdata
);

  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0]  DEPTH_L   = 3'(FIFO_DEPTH);
  localparam logic [8:0]  ROW_LIM   = 9'(V_PIX);
  localparam logic [9:0]  COL_LIM   = 10'(H_PIX);
  localparam logic [18:0] LAST_ADDR = 19'(H_PIX * V_PIX - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [18:0] r_clrAddr;
  logic [11:0] r_clrColor;
  logic        r_rdD;
  logic        r_oob;
  logic [2:0]  r_level;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [18:0] r_fifoAddr [FIFO_DEPTH];
  logic [11:0] r_fifoData [FIFO_DEPTH];

  logic        w_full;
  logic        w_empty;
  logic        w_inRange;
  logic        w_push;
  logic        w_pop;
  logic        w_clrWrite;

  // row*640 built from two shifts so no multiplier is needed
  function automatic logic [18:0] linAddr(input logic [8:0] row, input logic [9:0] col);
    logic [18:0] rowWide;
    rowWide = {10'd0, row};
    return (rowWide << 9) + (rowWide << 7) + {9'd0, col};
  endfunction

  assign w_full    = (r_level == DEPTH_L);
  assign w_empty   = (r_level == 3'd0);
  assign w_inRange = (wr_row < ROW_LIM) && (wr_col < COL_LIM);
  assign wr_ack    = wr_req & ~w_full & ~rst;
  assign w_push    = wr_ack & w_inRange;

  assign wr_oob     = r_oob;
  assign clear_busy = (r_state == ST_CLEAR);
  assign fifo_level = r_level;
  assign vga_data   = r_rdD ? ram_rdata : 12'h000;

  always_comb begin
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    w_pop      = 1'b0;
    w_clrWrite = 1'b0;
    if (!vga_rdn) begin
      ram_addr = linAddr(vga_row, vga_col);
    end else if (r_state == ST_CLEAR) begin
      ram_addr   = r_clrAddr;
      ram_we     = 1'b1;
      ram_wdata  = r_clrColor;
      w_clrWrite = 1'b1;
    end else if (!w_empty) begin
      ram_addr  = r_fifoAddr[r_rdPtr];
      ram_we    = 1'b1;
      ram_wdata = r_fifoData[r_rdPtr];
      w_pop     = 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (clear_req) w_nextState = ST_CLEAR;
      ST_CLEAR: if (w_clrWrite && (r_clrAddr == LAST_ADDR)) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // The clear walks a linear address, which matches row*640+col for H_PIX=640
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_clrAddr  <= '0;
      r_clrColor <= '0;
    end else if ((r_state == ST_IDLE) && clear_req) begin
      r_clrAddr  <= '0;
      r_clrColor <= clear_color;
    end else if (w_clrWrite) begin
      r_clrAddr <= r_clrAddr + 19'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_rdD   <= 1'b0;
      r_oob   <= 1'b0;
      r_level <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      r_rdD <= ~vga_rdn;
      r_oob <= wr_ack & ~w_inRange;
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (w_push) begin
      r_fifoAddr[r_wrPtr] <= linAddr(wr_row, wr_col);
      r_fifoData[r_wrPtr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural synchronous-read RAM;
// frame height is reduced to 16 lines so a full clear stays short.
module tb_fb_port_arbiter;

  localparam int VP = 16;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic        vga_rdn;
  logic [8:0]  vga_row;
  logic [9:0]  vga_col;
  logic [11:0] vga_data;
  logic        wr_req;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        wr_oob;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        clear_busy;
  logic [2:0]  fifo_level;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  logic [11:0] mem [0:307199];

  int checks = 0;
  int failures = 0;

  fb_port_arbiter #(.FIFO_DEPTH(4), .H_PIX(640), .V_PIX(VP)) dut (
    .vga_clk(vga_clk), .rst(rst),
    .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col), .vga_data(vga_data),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_oob(wr_oob),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .fifo_level(fifo_level),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #20 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input int row, input int col, input logic [11:0] data);
    wr_req  = req;
    wr_row  = 9'(row);
    wr_col  = 10'(col);
    wr_data = data;
  endtask

  initial begin
    int  expAddr;
    int  clearWrites;
    int  cyc;
    int  h;
    int  v;
    bit  found;
    bit  sawWrite;

    rst = 1'b1; vga_rdn = 1'b1; vga_row = '0; vga_col = '0;
    clear_req = 1'b0; clear_color = '0;
    applyStimulus(1'b1, 0, 0, 12'h000);
    step(); step();
    checkOutput("ackInReset", 32'(wr_ack), 32'd0);
    wr_req = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rstVgaData", 32'(vga_data), 32'd0);
    checkOutput("rstBusy", 32'(clear_busy), 32'd0);
    checkOutput("rstLevel", 32'(fifo_level), 32'd0);
    checkOutput("rstOob", 32'(wr_oob), 32'd0);
    checkOutput("rstWe", 32'(ram_we), 32'd0);

    // Write then read back
    applyStimulus(1'b1, 10, 20, 12'hABC);
    #1;
    checkOutput("wbAck", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0;
    #1;
    checkOutput("wbWe", 32'(ram_we), 32'd1);
    checkOutput("wbAddr", 32'(ram_addr), 32'd6420);
    checkOutput("wbData", 32'(ram_wdata), 32'hABC);
    checkOutput("wbLevel", 32'(fifo_level), 32'd1);
    step();
    vga_rdn = 1'b0; vga_row = 9'd10; vga_col = 10'd20;
    #1;
    checkOutput("rdAddr", 32'(ram_addr), 32'd6420);
    checkOutput("rdWe", 32'(ram_we), 32'd0);
    step();
    vga_rdn = 1'b1;
    #1;
    checkOutput("rdData", 32'(vga_data), 32'hABC);

    // VGA priority while the FIFO fills
    vga_rdn = 1'b0; vga_row = '0; vga_col = '0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, k + 1, k * 3, 12'(12'h100 + k));
      #1;
      checkOutput($sformatf("fillAck%0d", k), 32'(wr_ack), (k < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fillWe%0d", k), 32'(ram_we), 32'd0);
      step();
    end
    wr_req = 1'b0;
    #1;
    checkOutput("fillLevel", 32'(fifo_level), 32'd4);
    vga_rdn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("drainWe%0d", k), 32'(ram_we), 32'd1);
      checkOutput($sformatf("drainAddr%0d", k), 32'(ram_addr), 32'((k + 1) * 640 + k * 3));
      checkOutput($sformatf("drainData%0d", k), 32'(ram_wdata), 32'(12'h100 + k));
      checkOutput($sformatf("drainLevel%0d", k), 32'(fifo_level), 32'(4 - k));
      step();
    end
    checkOutput("drainEmpty", 32'(fifo_level), 32'd0);
    checkOutput("drainWeOff", 32'(ram_we), 32'd0);

    // Out-of-range writes are acked then dropped
    applyStimulus(1'b1, 480, 0, 12'h555);
    #1;
    checkOutput("oobRowAck", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0;
    #1;
    checkOutput("oobRowPulse", 32'(wr_oob), 32'd1);
    checkOutput("oobRowLevel", 32'(fifo_level), 32'd0);
    checkOutput("oobRowWe", 32'(ram_we), 32'd0);
    step();
    checkOutput("oobRowClr", 32'(wr_oob), 32'd0);
    applyStimulus(1'b1, 0, 640, 12'h555);
    #1;
    checkOutput("oobColAck", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0;
    #1;
    checkOutput("oobColPulse", 32'(wr_oob), 32'd1);
    checkOutput("oobColLevel", 32'(fifo_level), 32'd0);
    checkOutput("oobColWe", 32'(ram_we), 32'd0);
    step();
    checkOutput("oobColClr", 32'(wr_oob), 32'd0);

    // Full clear under scaled scan timing (800 clocks/line, 16 visible + 2 blank lines)
    clear_req = 1'b1; clear_color = 12'h00F;
    step();
    clear_req = 1'b0; clear_color = 12'hF0F;
    checkOutput("clrBusyRise", 32'(clear_busy), 32'd1);
    expAddr = 0;
    clearWrites = 0;
    cyc = 0;
    while (clear_busy && cyc < 60000) begin
      h = cyc % 800;
      v = (cyc / 800) % (VP + 2);
      vga_rdn = !(h < 640 && v < VP);
      vga_row = 9'(v);
      vga_col = 10'(h);
      if (cyc == 3000) applyStimulus(1'b1, 0, 0, 12'hFFF);
      else             wr_req = 1'b0;
      #1;
      if (cyc == 3000) checkOutput("clrWrAck", 32'(wr_ack), 32'd1);
      if (!vga_rdn) checkOutput("clrNoWeOnRead", 32'(ram_we), 32'd0);
      if (ram_we) begin
        checkOutput("clrAddr", 32'(ram_addr), 32'(expAddr));
        checkOutput("clrData", 32'(ram_wdata), 32'h00F);
        expAddr++;
        clearWrites++;
      end
      step();
      cyc++;
    end
    wr_req = 1'b0;
    checkOutput("clrDone", 32'(clear_busy), 32'd0);
    checkOutput("clrCount", 32'(clearWrites), 32'(640 * VP));
    checkOutput("clrHeldLevel", 32'(fifo_level), 32'd1);
    vga_rdn = 1'b1;
    #1;
    checkOutput("postClrWe", 32'(ram_we), 32'd1);
    checkOutput("postClrAddr", 32'(ram_addr), 32'd0);
    checkOutput("postClrData", 32'(ram_wdata), 32'hFFF);
    step();
    vga_rdn = 1'b0; vga_row = 9'd0; vga_col = 10'd0;
    step();
    vga_rdn = 1'b1;
    #1;
    checkOutput("readOrigin", 32'(vga_data), 32'hFFF);
    vga_rdn = 1'b0; vga_row = 9'(VP - 1); vga_col = 10'd639;
    step();
    vga_rdn = 1'b1;
    #1;
    checkOutput("readLastPix", 32'(vga_data), 32'h00F);

    // Reset in the middle of a clear with two writes queued
    clear_req = 1'b1; clear_color = 12'h123;
    step();
    clear_req = 1'b0;
    applyStimulus(1'b1, 1, 1, 12'h111);
    step();
    applyStimulus(1'b1, 2, 2, 12'h222);
    step();
    wr_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      #1;
      if (ram_we && ram_addr == 19'd1000) found = 1'b1;
      else step();
    end
    checkOutput("rstAt1000", 32'(found), 32'd1);
    checkOutput("rstQueued", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(clear_busy), 32'd0);
    checkOutput("midRstLevel", 32'(fifo_level), 32'd0);
    checkOutput("midRstWe", 32'(ram_we), 32'd0);
    sawWrite = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (ram_we) sawWrite = 1'b1;
    end
    checkOutput("midRstQuiet", 32'(sawWrite), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
